// File: rtl/symbol_timing_nco_pkg.sv
// Shared types and constants for the symbol-timing NCO and its lock detector.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package symbol_timing_nco_pkg;

    // Lock detector states; HOLD parks the loop while freeze is asserted.
    typedef enum logic [1:0] {
        LOCK_ACQUIRE = 2'd0,
        LOCK_TRACK   = 2'd1,
        LOCK_HOLD    = 2'd2
    } lock_state_t;

    // Nominal per-sample phase step: one full NCO turn spread over SPS samples.
    function automatic longint unsigned w_nom_calc(input int acc_width, input int sps);
        longint unsigned full_turn;
        full_turn = 64'd1 << acc_width;
        return full_turn / longint'(sps);
    endfunction

    // Lower clamp: the step may shrink to half of nominal.
    function automatic longint unsigned w_min_calc(input int acc_width, input int sps);
        return w_nom_calc(acc_width, sps) / 64'd2;
    endfunction

    // Upper clamp: the step may grow to one and a half times nominal.
    function automatic longint unsigned w_max_calc(input int acc_width, input int sps);
        return w_nom_calc(acc_width, sps) + (w_nom_calc(acc_width, sps) / 64'd2);
    endfunction

    // Only power-of-two oversampling ratios from 2 to 8 are supported.
    function automatic bit sps_legal(input int sps);
        return (sps == 2) || (sps == 4) || (sps == 8);
    endfunction

endpackage

// File: rtl/symbol_timing_nco_if.sv
// Sample-side bus of the symbol-timing NCO: sample/loop-filter inputs and timing outputs.
// Latency: n/a (wiring only).
// Backpressure: none; sample_valid and v_valid are plain qualifiers with no ready.
interface symbol_timing_nco_if #(
    parameter int V_WIDTH   = 16,
    parameter int ACC_WIDTH = 16,
    parameter int MU_WIDTH  = 10
) ();
    logic                        sample_valid;
    logic signed [V_WIDTH-1:0]   v_k;
    logic                        v_valid;
    logic                        freeze;
    logic                        strobe;
    logic        [MU_WIDTH-1:0]  mu;
    logic        [ACC_WIDTH-1:0] eta;
    logic                        locked;
    logic        [15:0]          sym_count;

    modport master (
        output sample_valid, v_k, v_valid, freeze,
        input  strobe, mu, eta, locked, sym_count
    );

    modport slave (
        input  sample_valid, v_k, v_valid, freeze,
        output strobe, mu, eta, locked, sym_count
    );
endinterface

// File: rtl/timing_lock_detector.sv
// Declares timing lock after LOCK_COUNT consecutive quiet symbols; drops it on one loud symbol.
// Latency: locked changes one cycle after the strobe that decides it.
// Backpressure: none; evaluated only on strobe cycles, frozen while freeze is high.
module timing_lock_detector
    import symbol_timing_nco_pkg::*;
#(
    parameter int V_WIDTH     = 16,
    parameter int LOCK_THRESH = 512,
    parameter int LOCK_COUNT  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      strobe,
    input  logic signed [V_WIDTH-1:0] v_reg,
    input  logic                      freeze,
    output logic                      locked
);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0]             CNT_TGT = CW'(LOCK_COUNT);
    localparam logic [V_WIDTH-1:0]        THRESH  = V_WIDTH'(LOCK_THRESH);
    localparam logic signed [V_WIDTH-1:0] V_MOST_NEG = {1'b1, {(V_WIDTH-1){1'b0}}};
    localparam logic [V_WIDTH-1:0]        V_MAX_MAG  = {1'b0, {(V_WIDTH-1){1'b1}}};

    lock_state_t   state, state_nxt;
    lock_state_t   prev, prev_nxt;
    logic [CW-1:0] quiet, quiet_nxt;
    logic          locked_nxt;
    logic [V_WIDTH-1:0] mag;
    logic          is_quiet;

    // |v_reg| with the most negative code saturated so it cannot wrap to itself.
    always_comb begin
        mag = v_reg;
        if (v_reg == V_MOST_NEG) begin
            mag = V_MAX_MAG;
        end else if (v_reg[V_WIDTH-1]) begin
            mag = V_WIDTH'(-v_reg);
        end
        is_quiet = (mag < THRESH);
    end

    // Lock state, remembered pre-freeze state, quiet-symbol counter and lock flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= LOCK_ACQUIRE;
            prev   <= LOCK_ACQUIRE;
            quiet  <= '0;
            locked <= 1'b0;
        end else begin
            state  <= state_nxt;
            prev   <= prev_nxt;
            quiet  <= quiet_nxt;
            locked <= locked_nxt;
        end
    end

    // Next-state logic; freeze takes priority over any strobe in the same cycle.
    always_comb begin
        state_nxt  = state;
        prev_nxt   = prev;
        quiet_nxt  = quiet;
        locked_nxt = locked;
        case (state)
            LOCK_ACQUIRE: begin
                if (freeze) begin
                    state_nxt = LOCK_HOLD;
                    prev_nxt  = LOCK_ACQUIRE;
                end else if (strobe) begin
                    if (!is_quiet) begin
                        quiet_nxt = '0;
                    end else if (quiet == CNT_TGT - CW'(1)) begin
                        quiet_nxt  = CNT_TGT;
                        state_nxt  = LOCK_TRACK;
                        locked_nxt = 1'b1;
                    end else begin
                        quiet_nxt = quiet + CW'(1);
                    end
                end
            end
            LOCK_TRACK: begin
                if (freeze) begin
                    state_nxt = LOCK_HOLD;
                    prev_nxt  = LOCK_TRACK;
                end else if (strobe && !is_quiet) begin
                    state_nxt  = LOCK_ACQUIRE;
                    quiet_nxt  = '0;
                    locked_nxt = 1'b0;
                end
            end
            LOCK_HOLD: begin
                if (!freeze) begin
                    state_nxt = prev;
                end
            end
            default: begin
                state_nxt = LOCK_ACQUIRE;
            end
        endcase
    end
endmodule

// File: rtl/symbol_timing_nco.sv
// Symbol-timing NCO: decrementing phase accumulator that strobes on underflow and reports mu.
// Latency: strobe/mu/eta reflect an accepted sample exactly one cycle later.
// Backpressure: none; the NCO advances only on sample_valid and holds otherwise.
module symbol_timing_nco
    import symbol_timing_nco_pkg::*;
#(
    parameter int ACC_WIDTH   = 16,
    parameter int V_WIDTH     = 16,
    parameter int V_SHIFT     = 4,
    parameter int MU_WIDTH    = 10,
    parameter int MU_FRAC     = 9,
    parameter int SPS         = 2,
    parameter int LOCK_THRESH = 512,
    parameter int LOCK_COUNT  = 16
) (
    input  logic               clk,
    input  logic               rst,
    symbol_timing_nco_if.slave bus
);
    if (!sps_legal(SPS)) begin : g_bad_sps
        $fatal(1, "symbol_timing_nco: SPS must be 2, 4 or 8");
    end

    localparam logic signed [ACC_WIDTH+1:0] W_NOM = (ACC_WIDTH+2)'(w_nom_calc(ACC_WIDTH, SPS));
    localparam logic signed [ACC_WIDTH+1:0] W_MIN = (ACC_WIDTH+2)'(w_min_calc(ACC_WIDTH, SPS));
    localparam logic signed [ACC_WIDTH+1:0] W_MAX = (ACC_WIDTH+2)'(w_max_calc(ACC_WIDTH, SPS));
    localparam logic [ACC_WIDTH+2:0]        MU_SAT   = (ACC_WIDTH+3)'((1 << MU_FRAC) - 1);
    localparam logic [MU_WIDTH-1:0]         MU_SAT_W = MU_WIDTH'((1 << MU_FRAC) - 1);

    logic signed [V_WIDTH-1:0]   v_reg;
    logic signed [ACC_WIDTH+1:0] v_adj, w_raw, w_sel;
    logic        [ACC_WIDTH-1:0] w_step;
    logic        [ACC_WIDTH-1:0] eta, eta_sub;
    logic                        underflow;
    logic        [ACC_WIDTH+2:0] mu_prod, mu_shift;
    logic        [MU_WIDTH-1:0]  mu, mu_next;
    logic                        strobe;
    logic        [15:0]          sym_count;
    logic                        locked;

    // Loop-filter capture; the NCO only sees this registered copy, never v_k directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_reg <= '0;
        end else if (bus.v_valid) begin
            v_reg <= bus.v_k;
        end
    end

    // Phase step: nominal plus scaled loop correction, clamped; freeze forces nominal.
    always_comb begin
        v_adj = (ACC_WIDTH+2)'(v_reg >>> V_SHIFT);
        w_raw = W_NOM + v_adj;
        if (bus.freeze) begin
            w_sel = W_NOM;
        end else if (w_raw < W_MIN) begin
            w_sel = W_MIN;
        end else if (w_raw > W_MAX) begin
            w_sel = W_MAX;
        end else begin
            w_sel = w_raw;
        end
        w_step = ACC_WIDTH'(w_sel);
    end

    // Underflow detect, wrapped accumulator and saturated fractional interval from eta_pre.
    always_comb begin
        underflow = (eta < w_step);
        eta_sub   = eta - w_step;
        mu_prod   = (ACC_WIDTH+3)'(eta) * (ACC_WIDTH+3)'(SPS);
        mu_shift  = mu_prod >> (ACC_WIDTH - MU_FRAC);
        mu_next   = (mu_shift > MU_SAT) ? MU_SAT_W : MU_WIDTH'(mu_shift);
    end

    // NCO state: advance per accepted sample; strobe is a one-cycle pulse on underflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eta       <= '1;
            mu        <= '0;
            strobe    <= 1'b0;
            sym_count <= '0;
        end else begin
            strobe <= 1'b0;
            if (bus.sample_valid) begin
                eta <= eta_sub;
                if (underflow) begin
                    strobe    <= 1'b1;
                    mu        <= mu_next;
                    sym_count <= sym_count + 16'd1;
                end
            end
        end
    end

    timing_lock_detector #(
        .V_WIDTH     (V_WIDTH),
        .LOCK_THRESH (LOCK_THRESH),
        .LOCK_COUNT  (LOCK_COUNT)
    ) u_lock (
        .clk    (clk),
        .rst    (rst),
        .strobe (strobe),
        .v_reg  (v_reg),
        .freeze (bus.freeze),
        .locked (locked)
    );

    assign bus.strobe    = strobe;
    assign bus.mu        = mu;
    assign bus.eta       = eta;
    assign bus.locked    = locked;
    assign bus.sym_count = sym_count;
endmodule

// File: tb/tb_symbol_timing_nco.sv
// Directed bench for symbol_timing_nco with a queue scoreboard checked by a separate monitor.
// Latency: expects every accepted sample's result one cycle later.
// Backpressure: none; the monitor keys off the samples the bench itself issued.
module tb_symbol_timing_nco;
    logic clk = 1'b0;
    logic rst;

    symbol_timing_nco_if bus ();

    symbol_timing_nco dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int eta;
        int st;
        int mu;
        int sc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endfunction

    task automatic drive(input bit sv, input int vk, input bit vv, input bit frz);
        @(negedge clk);
        bus.sample_valid = sv;
        bus.v_k          = 16'(vk);
        bus.v_valid      = vv;
        bus.freeze       = frz;
    endtask

    // Issue one accepted sample and queue the hand-computed response.
    task automatic samp(input int vk, input bit vv, input bit frz,
                        input int e_eta, input int e_st, input int e_mu, input int e_sc);
        exp_t e;
        drive(1'b1, vk, vv, frz);
        e.eta = e_eta;
        e.st  = e_st;
        e.mu  = e_mu;
        e.sc  = e_sc;
        sb.push_back(e);
    endtask

    // Monitor: one cycle after each accepted sample, compare outputs with the queue head.
    initial begin : monitor
        bit   took;
        exp_t e;
        forever begin
            @(posedge clk);
            took = bus.sample_valid && !rst;
            @(negedge clk);
            if (took && sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_eta",       int'(bus.eta),       e.eta);
                chk("sb_strobe",    int'(bus.strobe),    e.st);
                chk("sb_mu",        int'(bus.mu),        e.mu);
                chk("sb_sym_count", int'(bus.sym_count), e.sc);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst              = 1'b1;
        bus.sample_valid = 1'b0;
        bus.v_k          = '0;
        bus.v_valid      = 1'b0;
        bus.freeze       = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_eta",       int'(bus.eta),       65535);
        chk("rst_strobe",    int'(bus.strobe),    0);
        chk("rst_mu",        int'(bus.mu),        0);
        chk("rst_locked",    int'(bus.locked),    0);
        chk("rst_sym_count", int'(bus.sym_count), 0);
        rst = 1'b0;

        // Nominal SPS=2, v=0: strobe every second sample, mu saturates at 511.
        samp(0, 0, 0, 32767, 0,   0, 0);
        samp(0, 0, 0, 65535, 1, 511, 1);
        samp(0, 0, 0, 32767, 0, 511, 1);
        samp(0, 0, 0, 65535, 1, 511, 2);
        samp(0, 0, 0, 32767, 0, 511, 2);
        samp(0, 0, 0, 65535, 1, 511, 3);
        drive(1'b0, 0, 1'b0, 1'b0);
        // Idle cycle must hold state and drop the strobe; also capture v_k=16384.
        drive(1'b0, 16384, 1'b1, 1'b0);
        chk("idle_strobe",    int'(bus.strobe),    0);
        chk("idle_eta",       int'(bus.eta),       65535);
        chk("idle_sym_count", int'(bus.sym_count), 3);

        // W = 32768 + 1024 = 33792.
        samp(0, 0, 0, 31743, 0, 511, 3);
        samp(0, 0, 0, 63487, 1, 495, 4);
        samp(0, 0, 0, 29695, 0, 495, 4);
        samp(0, 0, 0, 61439, 1, 463, 5);
        // v_valid with sample_valid: this sample still uses W=33792; later W=34815.
        samp(32767, 1, 0, 27647, 0, 463, 5);
        samp(0, 0, 0, 58368, 1, 431, 6);
        samp(0, 0, 0, 23553, 0, 431, 6);
        samp(0, 0, 0, 54274, 1, 368, 7);
        // Most negative v: W = 32768 - 2048 = 30720.
        drive(1'b0, -32768, 1'b1, 1'b0);
        samp(0, 0, 0, 23554, 0, 368, 7);
        samp(0, 0, 0, 58370, 1, 368, 8);
        samp(0, 0, 0, 27650, 0, 368, 8);
        samp(0, 0, 0, 62466, 1, 432, 9);

        // Lock: |v|=100 gives W=32774, 16 strobes in 32 samples, eta drifts by -12 per symbol.
        drive(1'b0, 100, 1'b1, 1'b0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 100, 1'b0, 1'b0);
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        chk("lock_strobe16",   int'(bus.strobe),    1);
        chk("lock_pre_locked", int'(bus.locked),    0);
        chk("lock_sym_count",  int'(bus.sym_count), 25);
        chk("lock_eta",        int'(bus.eta),       62274);
        chk("lock_mu",         int'(bus.mu),        461);
        // Enter freeze with a loud v: W must stay nominal, lock must hold.
        drive(1'b0, 8000, 1'b1, 1'b1);
        chk("lock_rise", int'(bus.locked), 1);
        samp(0, 0, 1, 29506, 0, 461, 25);
        samp(0, 0, 1, 62274, 1, 461, 26);
        drive(1'b0, 0, 1'b0, 1'b1);
        chk("frz_locked_a", int'(bus.locked), 1);
        // Release freeze and make the loop quiet again (W=32774).
        drive(1'b0, 100, 1'b1, 1'b0);
        chk("frz_locked_b", int'(bus.locked), 1);
        samp(0, 0, 0, 29500, 0, 461, 26);
        samp(0, 0, 0, 62262, 1, 460, 27);
        // Loud v=600: W=32805; the next strobe in TRACK drops lock.
        drive(1'b0, 600, 1'b1, 1'b0);
        samp(0, 0, 0, 29457, 0, 460, 27);
        chk("track_kept", int'(bus.locked), 1);
        samp(0, 0, 0, 62188, 1, 460, 28);
        drive(1'b0, 0, 1'b0, 1'b0);
        chk("fall_pre", int'(bus.locked), 1);
        samp(0, 0, 0, 29383, 0, 460, 28);
        chk("fall_post", int'(bus.locked), 0);

        // Asynchronous reset mid-symbol: outputs clear with no clock edge.
        drive(1'b0, 0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_eta",       int'(bus.eta),       65535);
        chk("arst_mu",        int'(bus.mu),        0);
        chk("arst_strobe",    int'(bus.strobe),    0);
        chk("arst_locked",    int'(bus.locked),    0);
        chk("arst_sym_count", int'(bus.sym_count), 0);
        @(negedge clk);
        rst = 1'b0;
        // v_reg cleared by reset: first strobe on the second sample.
        samp(0, 0, 0, 32767, 0,   0, 0);
        samp(0, 0, 0, 65535, 1, 511, 1);
        drive(1'b0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        chk("sb_drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/symbol_timing_nco.md
SYMBOL_TIMING_NCO -- requirements
Module: symbol_timing_nco

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ACC_WIDTH, 16: NCO register width, unsigned Q0.ACC_WIDTH.
- V_WIDTH, 16: loop-filter input width, signed Q1.15.
- V_SHIFT, 4: arithmetic right shift applied to v_k before it is added to W.
- MU_WIDTH, 10: width of the mu output.
- MU_FRAC, 9: fractional bits of mu.
- SPS, 2: samples per symbol; legal values 2, 4, 8.
- LOCK_THRESH, 512: |v_k| bound for a "quiet" symbol.
- LOCK_COUNT, 16: consecutive quiet symbols required to declare lock.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- sample_valid, in, 1: advances the NCO by one input sample.
- v_k, in, V_WIDTH: loop-filter output.
- v_valid, in, 1: v_k qualifier.
- freeze, in, 1: holds the loop open.
- strobe, out, 1: underflow, i.e. symbol instant.
- mu, out, MU_WIDTH: fractional interval, unsigned.
- eta, out, ACC_WIDTH: NCO register.
- locked, out, 1: lock indicator.
- sym_count, out, 16: symbols since reset, wrapping.

Function
REQ-003 The block SHALL capture v_k into v_reg on any cycle with v_valid=1; the NCO SHALL use only v_reg, so a value captured in cycle n first affects the sample update in cycle n+1.
REQ-004 W_NOM SHALL equal 2^ACC_WIDTH / SPS. W SHALL equal W_NOM + (v_reg >>> V_SHIFT), sign-extended, computed at ACC_WIDTH+2 bits.
REQ-005 W SHALL be clamped to the range [W_NOM/2, W_NOM + W_NOM/2].
REQ-006 When freeze=1, W SHALL equal W_NOM and v_reg SHALL be ignored.
REQ-007 On sample_valid=1 with eta >= W: eta SHALL become eta - W and strobe SHALL be 0 in the next cycle.
REQ-008 On sample_valid=1 with eta < W: eta SHALL become eta - W + 2^ACC_WIDTH (modulo wrap), and in the next cycle strobe SHALL be 1 and mu SHALL update.
REQ-009 mu SHALL be (eta_pre * SPS) >> (ACC_WIDTH - MU_FRAC), saturated to 2^MU_FRAC - 1. eta_pre is the eta value before the update.
REQ-010 strobe SHALL be a single-cycle pulse. mu SHALL hold between strobes.
REQ-011 On sample_valid=0, eta, mu and sym_count SHALL hold and strobe SHALL be 0.
REQ-012 Latency from a sample_valid edge to strobe/mu SHALL be exactly 1 cycle.
REQ-013 sym_count SHALL increment on each strobe and wrap from 0xFFFF to 0.
REQ-014 The lock FSM SHALL have three states: ACQUIRE, TRACK and HOLD.
REQ-015 In ACQUIRE, on each strobe the quiet counter SHALL increment if |v_reg| < LOCK_THRESH and clear otherwise. When the counter reaches LOCK_COUNT the FSM SHALL go to TRACK and set locked=1.
REQ-016 In TRACK, a strobe with |v_reg| >= LOCK_THRESH SHALL return the FSM to ACQUIRE, clear the counter and clear locked on the next cycle.
REQ-017 From ACQUIRE or TRACK, freeze=1 SHALL move the FSM to HOLD. HOLD keeps locked and the counter unchanged. freeze=0 SHALL return the FSM to the state it came from.
REQ-018 The magnitude of v_reg = -2^(V_WIDTH-1) SHALL saturate to 2^(V_WIDTH-1) - 1.
REQ-019 When v_valid and sample_valid are asserted together, the NCO SHALL use the old v_reg (per REQ-003).

Reset
REQ-020 When rst is asserted, the block SHALL immediately set eta = 2^ACC_WIDTH - 1, mu = 0, strobe = 0, locked = 0, sym_count = 0, v_reg = 0, quiet counter = 0 and state = ACQUIRE.
REQ-021 Assertion of rst mid-symbol SHALL discard the partial NCO phase. The first strobe after release SHALL occur on the SPS-th accepted sample when v_reg = 0.

Structure
REQ-022 A shared package SHALL hold:
- the lock-state enumerated type;
- W_NOM and the clamp-limit derivation functions;
- the legal-SPS check.
REQ-023 The lock FSM SHALL be a separate sub-module named timing_lock_detector, with inputs strobe, v_reg and freeze, and output locked.
REQ-024 An elaboration-time check SHALL reject SPS values outside {2, 4, 8}.

Verification
REQ-025 Nominal run: SPS=2, v_k=0, sample_valid held high. Required: eta sequence 65535, 32767, 65535; strobe every 2nd cycle; mu = 511.
REQ-026 Adjusted W: v_k = +16384 with v_valid for 1 cycle, then sample updates. Required: W = 33792 (observed through eta decrements); strobe period shortens.
REQ-027 Clamp: v_k = +32767 (W_adj = +2047, in range) and v_k = -32768. Required: W never leaves [16384, 49152].
REQ-028 Lock: 16 strobes with |v_k| = 100 → locked rises one cycle after the 16th strobe. One strobe with v_k = 600 → locked falls.
REQ-029 Freeze: freeze=1 while v_k = 8000. Required: W = 32768 and locked is held. On release the FSM returns to its prior state.
REQ-030 Reset mid-symbol: rst asserted with eta = 20000. Required: all outputs take their REQ-020 values immediately; the first strobe comes 2 samples after release.
